// File: rtl/iqueue_issue.sv
// In-order instruction issue queue with a 32-entry register busy scoreboard.
// Decoded instructions wait in a circular FIFO until the head is free of
// RAW/WAW hazards, then issue as a registered one-cycle issue_rdy pulse.
// Optional feature macro: IQ_BYPASS_EN (empty-queue direct issue).
module iqueue_issue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic              dec_is_vec,
  input  logic              dec_is_imm,
  input  logic              dec_is_pc,
  input  logic [31:0]       dec_pc,
  input  logic [31:0]       dec_imm,
  input  logic [5:0]        dec_name,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_has_rd,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  output logic              issue_rdy,
  output logic              is_vec,
  output logic              is_imm,
  output logic              is_pc,
  output logic [31:0]       pc,
  output logic [31:0]       imm,
  output logic [5:0]        name,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  output logic [4:0]        issue_rd,
  output logic [ADDR_W:0]   count
);

  typedef struct packed {
    logic        is_vec;
    logic        is_imm;
    logic        is_pc;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  name;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        has_rd;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [31:0]       busy;
  logic [31:0]       busy_eff;
  logic [31:0]       busy_nxt;
  entry_t            dec_e;
  entry_t            head_e;
  entry_t            iss_e;
  logic              head_haz;
  logic              push;
  logic              pop;
  logic              bypass;
  logic              issue;
  logic              store;

  // RAW on either source or WAW on the destination; x0 never conflicts
  function automatic logic hazard(input entry_t e, input logic [31:0] b);
    return (e.use_rs1 && (e.rs1 != 5'd0) && b[e.rs1]) ||
           (e.use_rs2 && (e.rs2 != 5'd0) && b[e.rs2]) ||
           (e.has_rd  && (e.rd  != 5'd0) && b[e.rd]);
  endfunction

  assign dec_e = '{is_vec: dec_is_vec, is_imm: dec_is_imm, is_pc: dec_is_pc,
                   pc: dec_pc, imm: dec_imm, name: dec_name,
                   rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd,
                   use_rs1: dec_use_rs1, use_rs2: dec_use_rs2, has_rd: dec_has_rd};
  assign head_e    = mem[head];
  assign dec_ready = (count != (ADDR_W+1)'(DEPTH));

  // Writeback landing this cycle already unblocks dependent instructions
  always_comb begin
    busy_eff = busy;
    if (wb_valid) busy_eff[wb_rd] = 1'b0;
  end

  assign head_haz = hazard(head_e, busy_eff);
  assign push     = dec_valid && dec_ready && rdy && !flush;
  assign pop      = (count != '0) && rdy && !flush && !head_haz;

`ifdef IQ_BYPASS_EN
  logic dec_haz;
  assign dec_haz = hazard(dec_e, busy_eff);
  assign bypass  = push && (count == '0) && !dec_haz;
`else
  assign bypass  = 1'b0;
`endif

  assign issue = pop || bypass;
  assign iss_e = pop ? head_e : dec_e;
  assign store = push && !bypass;

  // Scoreboard next value: clear on writeback, set on issue (set wins)
  always_comb begin
    busy_nxt = busy_eff;
    if (issue && iss_e.has_rd && (iss_e.rd != 5'd0)) busy_nxt[iss_e.rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Entry storage; no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (store) mem[tail] <= dec_e;
  end

  // Pointers, occupancy, scoreboard and registered issue bus
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy      <= '0;
      issue_rdy <= 1'b0;
      is_vec    <= 1'b0;
      is_imm    <= 1'b0;
      is_pc     <= 1'b0;
      pc        <= '0;
      imm       <= '0;
      name      <= '0;
      rs1_addr  <= '0;
      rs2_addr  <= '0;
      issue_rd  <= '0;
    end else if (rdy) begin
      busy <= busy_nxt;
      if (flush) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        issue_rdy <= 1'b0;
      end else begin
        if (store) tail <= ADDR_W'(tail + 1'b1);
        if (pop)   head <= ADDR_W'(head + 1'b1);
        if (store && !pop)      count <= (ADDR_W+1)'(count + 1'b1);
        else if (pop && !store) count <= (ADDR_W+1)'(count - 1'b1);
        issue_rdy <= issue;
        if (issue) begin
          is_vec   <= iss_e.is_vec;
          is_imm   <= iss_e.is_imm;
          is_pc    <= iss_e.is_pc;
          pc       <= iss_e.pc;
          imm      <= iss_e.imm;
          name     <= iss_e.name;
          rs1_addr <= iss_e.rs1;
          rs2_addr <= iss_e.rs2;
          issue_rd <= iss_e.has_rd ? iss_e.rd : 5'd0;
        end
      end
    end
  end

endmodule

// File: doc/iqueue_issue.md
Name: iqueue_issue

Overview:
- In-order instruction issue queue: the initiator side of the scalar ALU issue interface.
- Buffers decoded instructions in a circular FIFO and checks register hazards against a 32-entry busy scoreboard.
- Issues at most one instruction per cycle as a registered issue_rdy pulse, together with operand-select fields and register-file read addresses.
- The register file reads combinationally, so op1/op2 are valid in the issue_rdy cycle; both the scalar ALU and the vector path consume the same issue bus.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
ADDR_W, 3, log2(DEPTH); pointer width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low, all state holds and issue_rdy holds its value
flush  in  1  discard all queued entries
dec_valid  in  1  decoder offers an instruction
dec_ready  out  1  queue can accept; equals (count != DEPTH)
dec_is_vec  in  1  vector instruction
dec_is_imm  in  1  use imm instead of rs2
dec_is_pc  in  1  use pc instead of rs1
dec_pc  in  32  instruction pc
dec_imm  in  32  immediate
dec_name  in  6  opcode name code
dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
dec_use_rs1, dec_use_rs2, dec_has_rd  in  1 each  operand/destination valid
wb_valid  in  1  writeback completes this cycle
wb_rd  in  5  register being written back
issue_rdy  out  1  one-cycle issue pulse
is_vec, is_imm, is_pc  out  1 each  issued fields
pc, imm  out  32 each  issued fields
name  out  6  issued opcode
rs1_addr, rs2_addr  out  5 each  register-file read addresses
issue_rd  out  5  destination of issued instruction (0 if !has_rd)
count  out  ADDR_W+1  occupancy

Behaviour:
- Reset: pointers 0, count 0, scoreboard all 0, every output register 0; dec_ready=1. Reset mid-operation drops all entries and in-flight busy bits.
- Push: fires when dec_valid && dec_ready && rdy && !flush. Entry is written at the tail; the tail wraps from DEPTH-1 to 0.
- Hazard at head, using busy_eff = busy with bit wb_rd cleared when wb_valid:
  - RAW: use_rs1 && rs1!=0 && busy_eff[rs1], or the same for rs2.
  - WAW: has_rd && rd!=0 && busy_eff[rd].
- Pop: fires when count>0 && rdy && !flush && no hazard.
  - At the edge: issue_rdy<=1, fields<=head entry, head advances with wrap.
  - busy[rd] is set if has_rd && rd!=0.
  - Without a pop, issue_rdy<=0; fields hold their last values.
- Scoreboard clear: on each rdy edge, wb_valid clears busy[wb_rd].
  - If the same edge sets and clears the same register, set wins.
  - x0 is never busy.
- Simultaneous push and pop: count unchanged. Push at full is blocked by dec_ready=0, even if a pop occurs that cycle.
- Latency without bypass: an entry pushed at edge N first issues at edge N+1, so issue_rdy is high in the cycle after N+1. Throughput is 1 per cycle when there are no hazards.
- Flush:
  - At the edge: pointers and count go to 0, and issue_rdy<=0.
  - The scoreboard is retained, because in-flight ops still write back; wb clears still apply.
  - Flush beats push and pop in the same cycle.
- rdy low: nothing changes, including the scoreboard. wb_valid is ignored, so the writeback stage must hold it until rdy.
- Fields are passed unchanged; is_vec entries issue and occupy the scoreboard the same way scalar entries do.

Optional Feature:
- IQ_BYPASS_EN defined:
  - When count==0, a push that would be hazard-free (checked with busy_eff on the dec_* fields) issues directly at the same edge.
  - The entry is not written and the pointers are unchanged; the scoreboard is set as for a pop.
  - Zero-cycle residency: issue_rdy is high in the cycle after the push edge.
- IQ_BYPASS_EN undefined: every instruction spends at least one cycle in the queue; the latency is as in Behaviour.

Test Plan:
- Reset, then push ADD (rd=5, rs1=1, rs2=2, pc=0x100) at edge 1 -> issue_rdy=1 after edge 2 with pc=0x100, rs1_addr=1, rs2_addr=2, issue_rd=5; busy[5]=1; count=0 after edge 2.
- Push ADD rd=5, then SUB rs1=5; no writeback -> SUB stalls with issue_rdy=0. Pulse wb_valid with wb_rd=5 -> SUB issues on that same edge.
- Push 8 entries with hazards blocking issue -> dec_ready=0 and count=8; 9th dec_valid is ignored. Clear the hazard -> 8 consecutive issue_rdy pulses in push order, pointers wrap, count returns to 0.
- Full queue with dec_valid=1 and a pop in the same cycle -> count goes from 8 to 7 and the new entry is not taken. Queue at count=3 with a push and a pop in the same cycle -> count stays 3.
- Flush with 4 entries queued and busy[7]=1 -> count=0, issue_rdy=0 after the edge, busy[7] still 1. A later wb_valid with wb_rd=7 clears it. rdy=0 for 3 cycles mid-stream -> no state change.
- LUI rd=0 with is_imm=1 and imm=0x12345000 -> issues with imm=0x12345000, issue_rd=0, no busy bit set. With IQ_BYPASS_EN and an empty queue -> issue_rdy is high one cycle after the push edge.
